calc_engine: RTL and testbench
==============================

CALC_ENGINE -- requirements
Module: calc_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand and result width in bits, legal range 8..128.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high, with one clock only.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  engine can accept a request.
REQ-006 SHALL have port a  input  WIDTH  unsigned operand A.
REQ-007 SHALL have port b  input  WIDTH  unsigned operand B.
REQ-008 SHALL have port mode  input  4  opcode: 0 add, 1 sub, 2 mul, 3 div, 4 rem (macro-gated).
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port result  output  WIDTH  operation result.
REQ-012 SHALL have port flags  output  4  status flags: bit0 carry/borrow, bit1 mul overflow, bit2 div-by-zero, bit3 illegal mode.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, DIV, DONE, held in a single state register.
REQ-014 SHALL drive in_ready high only in IDLE; a request SHALL be accepted on a clock edge where in_valid && in_ready, capturing a, b and mode.
REQ-015 SHALL transition IDLE->EXEC on accept; EXEC->DIV for mode 3/4 with b!=0; otherwise EXEC->DONE.
REQ-016 SHALL compute add as a+b truncated to WIDTH, with flags[0] = carry-out.
REQ-017 SHALL compute sub as a-b modulo 2^WIDTH, with flags[0]=1 when a<b.
REQ-018 SHALL compute mul as the low WIDTH bits of the 2*WIDTH product, with flags[1]=1 when the upper WIDTH bits are nonzero.
REQ-019 SHALL compute div by unsigned restoring division, one quotient bit per cycle, WIDTH cycles spent in DIV, then DIV->DONE.
REQ-020 SHALL, for div/rem with b==0, skip DIV, set result to all ones and flags[2]=1.
REQ-021 SHALL, for mode values 5..15 (and 4 when rem is compiled out), set result to 0 and flags[3]=1.
REQ-022 SHALL give latency, accept edge to out_valid high, of 2 cycles for non-divide and error cases, and WIDTH+2 cycles for divide/rem.
REQ-023 SHALL assert out_valid only in DONE, holding result and flags stable until out_ready is sampled high; DONE->IDLE on that edge.
REQ-024 SHALL leave flag bits not defined for the executed operation at 0.
REQ-025 SHALL NOT accept a new request in DONE even when out_ready is high; in_ready rises the cycle after the handoff.
REQ-026 SHALL ignore operand and mode input changes after accept for the in-flight operation.

Reset
REQ-027 SHALL, when rst is high at a clock edge, force state=IDLE, result=0, flags=0, out_valid=0 and in_ready=1 on the following cycle.
REQ-028 SHALL, on reset mid-operation (EXEC, DIV or DONE), discard the in-flight operation with no partial result emitted.
REQ-029 SHALL give rst priority over in_valid and out_ready on the same edge.

Configuration
REQ-030 SHALL, with CALC_ENGINE_REM_EN defined, support mode 4, returning a mod b via the DIV path with the same latency as div, and the b==0 handling of REQ-020.
REQ-031 SHALL, without CALC_ENGINE_REM_EN, treat mode 4 as illegal per REQ-021 and omit the remainder output logic.

Structure
REQ-032 SHALL place the mode opcode constants, the FSM state enum and the flag bit index constants in shared package calc_pkg.
REQ-033 SHALL isolate the iterative divider in sub-module calc_seq_div (start/done, quotient and remainder outputs, parameter WIDTH).

Verification
REQ-034 SHALL cover, with WIDTH=8: add a=0xF0, b=0x20 -> result 0x10, flags=0001, out_valid 2 cycles after accept.
REQ-035 SHALL cover, with WIDTH=8: mul a=0x10, b=0x11 -> result 0x10, flags=0010; sub a=3, b=5 -> result 0xFE, flags=0001.
REQ-036 SHALL cover, with WIDTH=8: div a=200, b=7 -> result 28, out_valid at accept+10; with REM_EN, rem -> 4.
REQ-037 SHALL cover div a=5, b=0 -> result all ones, flags=0100 at accept+2; mode 9 -> result 0, flags=1000.
REQ-038 SHALL cover holding out_ready low for 5 cycles in DONE -> result, flags and out_valid stable, in_ready low throughout.
REQ-039 SHALL cover asserting rst at cycle 3 of DIV -> next cycle IDLE, out_valid 0, in_ready 1, with no result ever emitted.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg -- shared constants for the calc_engine slice.
//
// Contents:
//   MODE_*  : 4-bit opcode values presented on calc_engine.mode
//   ST_*    : calc_engine FSM state encodings (single 2-bit state register)
//   FLAG_*  : bit positions inside calc_engine.flags
//   uses_divider() : true for opcodes that run through the iterative divider
//
// Configuration macro: CALC_ENGINE_REM_EN (enables the remainder opcode).
package calc_pkg;

  localparam logic [3:0] MODE_ADD = 4'd0;
  localparam logic [3:0] MODE_SUB = 4'd1;
  localparam logic [3:0] MODE_MUL = 4'd2;
  localparam logic [3:0] MODE_DIV = 4'd3;
  localparam logic [3:0] MODE_REM = 4'd4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int FLAG_CARRY    = 0;
  localparam int FLAG_MUL_OVF  = 1;
  localparam int FLAG_DIV_ZERO = 2;
  localparam int FLAG_ILLEGAL  = 3;

  // Opcodes whose result comes from the sequential divider.
  function automatic logic uses_divider(input logic [3:0] op);
`ifdef CALC_ENGINE_REM_EN
    return (op == MODE_DIV) || (op == MODE_REM);
`else
    return (op == MODE_DIV);
`endif
  endfunction

endpackage

// File: rtl/calc_seq_div.sv
// calc_seq_div -- unsigned restoring divider, one quotient bit per clock.
//
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   start      : pulse; latches dividend/divisor and performs the first step
//   dividend   : WIDTH-bit unsigned dividend
//   divisor    : WIDTH-bit unsigned divisor (must be nonzero)
//   done       : one-cycle pulse, quotient/remainder are final while high
//   quotient   : WIDTH-bit quotient (holds until the next start)
//   remainder  : WIDTH-bit remainder (holds until the next start)
//
// The first of the WIDTH steps is folded into the start cycle, so done
// rises WIDTH cycles after start.
module calc_seq_div #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    steps_left;
  logic             busy;
  logic [WIDTH-1:0] divisor_r;

  // One restoring step: shift the next dividend bit into the partial
  // remainder, subtract the divisor, keep the difference only if it did not
  // go negative. Returns {remainder, quotient}; the quotient register doubles
  // as the shift register for the remaining dividend bits.
  function automatic logic [2*WIDTH-1:0] div_step(
    input logic [WIDTH-1:0] rem,
    input logic [WIDTH-1:0] quo,
    input logic [WIDTH-1:0] dvs
  );
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    if (diff[WIDTH])
      return {shifted[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
    else
      return {diff[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      steps_left <= '0;
      divisor_r  <= '0;
      quotient   <= '0;
      remainder  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        {remainder, quotient} <= div_step('0, dividend, divisor);
        divisor_r  <= divisor;
        steps_left <= CW'(WIDTH - 1);
        busy       <= 1'b1;
      end else if (busy) begin
        {remainder, quotient} <= div_step(remainder, quotient, divisor_r);
        steps_left <= steps_left - CW'(1);
        if (steps_left == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/calc_engine.sv
// calc_engine -- multi-cycle unsigned arithmetic unit with valid/ready
// handshakes on both sides.
//
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   in_valid   : request present (a, b, mode sampled on accept)
//   in_ready   : high only while idle
//   a, b       : WIDTH-bit unsigned operands
//   mode       : 0 add, 1 sub, 2 mul, 3 div, 4 rem (when enabled), else illegal
//   out_valid  : result present, held until out_ready
//   out_ready  : consumer takes the result
//   result     : WIDTH-bit result
//   flags      : {illegal, div-by-zero, mul overflow, carry/borrow}
//
// Configuration macro: CALC_ENGINE_REM_EN adds the remainder opcode (mode 4).
// Without it mode 4 is reported as illegal.
module calc_engine
  import calc_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [3:0]       mode_r;
  logic [WIDTH-1:0] result_r;
  logic [3:0]       flags_r;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   exec_result;
  logic [3:0]         exec_flags;

  logic             div_start;
  logic             div_done;
  logic [WIDTH-1:0] div_quotient;
  logic [WIDTH-1:0] div_remainder;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign result    = result_r;
  assign flags     = flags_r;

  assign sum     = {1'b0, a_r} + {1'b0, b_r};
  assign product = {{WIDTH{1'b0}}, a_r} * {{WIDTH{1'b0}}, b_r};

  // A divide with a nonzero divisor leaves EXEC for the divider; every
  // other opcode (including divide-by-zero) finishes straight out of EXEC.
  assign div_start = (state == ST_EXEC) && uses_divider(mode_r) && (b_r != '0);

  // Single-cycle results. The divide entries are only reached when the
  // divisor is zero, since nonzero divisors go through the divider instead.
  always_comb begin
    exec_result = '0;
    exec_flags  = '0;
    case (mode_r)
      MODE_ADD: begin
        exec_result             = sum[WIDTH-1:0];
        exec_flags[FLAG_CARRY]  = sum[WIDTH];
      end
      MODE_SUB: begin
        exec_result             = a_r - b_r;
        exec_flags[FLAG_CARRY]  = (a_r < b_r);
      end
      MODE_MUL: begin
        exec_result               = product[WIDTH-1:0];
        exec_flags[FLAG_MUL_OVF]  = |product[2*WIDTH-1:WIDTH];
      end
      MODE_DIV: begin
        exec_result                = '1;
        exec_flags[FLAG_DIV_ZERO]  = 1'b1;
      end
`ifdef CALC_ENGINE_REM_EN
      MODE_REM: begin
        exec_result                = '1;
        exec_flags[FLAG_DIV_ZERO]  = 1'b1;
      end
`else
      MODE_REM: begin
        exec_flags[FLAG_ILLEGAL] = 1'b1;
      end
`endif
      default: begin
        exec_flags[FLAG_ILLEGAL] = 1'b1;
      end
    endcase
  end

  calc_seq_div #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (a_r),
    .divisor   (b_r),
    .done      (div_done),
    .quotient  (div_quotient),
    .remainder (div_remainder)
  );

`ifndef CALC_ENGINE_REM_EN
  logic unused_remainder;
  assign unused_remainder = ^div_remainder;
`endif

  // Control FSM. Operands are captured on accept so later input changes
  // cannot disturb the operation in flight; result and flags only change
  // on entry to DONE and stay put until the consumer takes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      a_r      <= '0;
      b_r      <= '0;
      mode_r   <= '0;
      result_r <= '0;
      flags_r  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_r    <= a;
            b_r    <= b;
            mode_r <= mode;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (div_start) begin
            state <= ST_DIV;
          end else begin
            result_r <= exec_result;
            flags_r  <= exec_flags;
            state    <= ST_DONE;
          end
        end
        ST_DIV: begin
          if (div_done) begin
`ifdef CALC_ENGINE_REM_EN
            result_r <= (mode_r == MODE_REM) ? div_remainder : div_quotient;
`else
            result_r <= div_quotient;
`endif
            flags_r  <= '0;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_engine.sv
// tb_calc_engine -- self-checking bench for calc_engine at WIDTH=8.
// Expected values come from a plain-arithmetic reference model.
module tb_calc_engine;

  localparam int W = 8;
  localparam int LAT_LIMIT = 100;
`ifdef CALC_ENGINE_REM_EN
  localparam bit REM_EN = 1'b1;
`else
  localparam bit REM_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   mode = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic [3:0]   flags;

  int checks = 0;
  int passes = 0;

  calc_engine #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  // Reference model: result, flags and accept-to-out_valid latency.
  function automatic void model(input logic [7:0] ma, input logic [7:0] mb,
                                input logic [3:0] mm, output logic [7:0] r,
                                output logic [3:0] f, output int lat);
    int unsigned ua, ub, t;
    ua = ma; ub = mb; f = 4'b0000; lat = 2; r = 8'h00;
    if (mm == 4'd0) begin
      t = ua + ub; r = 8'(t % 256); f[0] = (t > 255);
    end else if (mm == 4'd1) begin
      t = (ua + 256 - ub) % 256; r = 8'(t); f[0] = (ua < ub);
    end else if (mm == 4'd2) begin
      t = ua * ub; r = 8'(t % 256); f[1] = (t > 255);
    end else if (mm == 4'd3 || (mm == 4'd4 && REM_EN)) begin
      if (ub == 0) begin
        r = 8'hFF; f[2] = 1'b1;
      end else begin
        t = (mm == 4'd3) ? (ua / ub) : (ua % ub);
        r = 8'(t); lat = W + 2;
      end
    end else begin
      f[3] = 1'b1;
    end
  endfunction

  // Present one request, scramble the inputs after accept, and wait
  // (bounded) for out_valid. Latency counts the accept edge as edge 1.
  task automatic start_op(input logic [7:0] oa, input logic [7:0] ob,
                          input logic [3:0] om, output logic [7:0] got_r,
                          output logic [3:0] got_f, output int got_lat);
    @(negedge clk);
    a = oa; b = ob; mode = om; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); mode = 4'($urandom);
    got_lat = 1;
    while (!out_valid && got_lat < LAT_LIMIT) begin
      @(posedge clk); #1;
      got_lat++;
    end
    got_r = result; got_f = flags;
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; a = 8'h12; b = 8'h34;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); else passes++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); else passes++;
    checks++; if (result !== 8'h00) $display("[TB] FAIL reset_result got %h want 00", result); else passes++;
    checks++; if (flags !== 4'b0000) $display("[TB] FAIL reset_flags got %b want 0000", flags); else passes++;
  endtask

  task automatic test_directed();
    logic [7:0] va [8] = '{8'hF0, 8'h10, 8'd3, 8'd200, 8'd200, 8'd5, 8'd7, 8'hFF};
    logic [7:0] vb [8] = '{8'h20, 8'h11, 8'd5, 8'd7,   8'd7,   8'd0, 8'd1, 8'h01};
    logic [3:0] vm [8] = '{4'd0,  4'd2,  4'd1, 4'd3,   4'd4,   4'd3, 4'd9, 4'd0};
    logic [7:0] er, gr;
    logic [3:0] ef, gf;
    int el, gl;
    for (int i = 0; i < 8; i++) begin
      model(va[i], vb[i], vm[i], er, ef, el);
      start_op(va[i], vb[i], vm[i], gr, gf, gl);
      checks++; if (gr !== er) $display("[TB] FAIL directed%0d_result got %h want %h", i, gr, er); else passes++;
      checks++; if (gf !== ef) $display("[TB] FAIL directed%0d_flags got %b want %b", i, gf, ef); else passes++;
      checks++; if (gl != el) $display("[TB] FAIL directed%0d_latency got %0d want %0d", i, gl, el); else passes++;
      finish_op();
    end
  endtask

  task automatic test_random();
    logic [7:0] ra, rb, er, gr;
    logic [3:0] rm, ef, gf;
    int el, gl;
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      rm = ($urandom_range(0, 6) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
      model(ra, rb, rm, er, ef, el);
      start_op(ra, rb, rm, gr, gf, gl);
      checks++; if (gr !== er) $display("[TB] FAIL random%0d_result a=%h b=%h m=%0d got %h want %h", i, ra, rb, rm, gr, er); else passes++;
      checks++; if (gf !== ef) $display("[TB] FAIL random%0d_flags got %b want %b", i, gf, ef); else passes++;
      checks++; if (gl != el) $display("[TB] FAIL random%0d_latency got %0d want %0d", i, gl, el); else passes++;
      finish_op();
    end
  endtask

  task automatic test_hold();
    logic [7:0] er, gr;
    logic [3:0] ef, gf;
    int el, gl;
    model(8'hC8, 8'h64, 4'd0, er, ef, el);
    start_op(8'hC8, 8'h64, 4'd0, gr, gf, gl);
    checks++; if (gl != el) $display("[TB] FAIL hold_latency got %0d want %0d", gl, el); else passes++;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) $display("[TB] FAIL hold%0d_out_valid got %b want 1", i, out_valid); else passes++;
      checks++; if (result !== er) $display("[TB] FAIL hold%0d_result got %h want %h", i, result, er); else passes++;
      checks++; if (flags !== ef) $display("[TB] FAIL hold%0d_flags got %b want %b", i, flags, ef); else passes++;
      checks++; if (in_ready !== 1'b0) $display("[TB] FAIL hold%0d_in_ready got %b want 0", i, in_ready); else passes++;
    end
    // A request offered during the handoff edge must not be taken.
    a = 8'h01; b = 8'h01; mode = 4'd0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL handoff_in_ready got %b want 1", in_ready); else passes++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL handoff_out_valid got %b want 0", out_valid); else passes++;
  endtask

  task automatic test_reset_mid_div();
    int seen;
    logic [7:0] er, gr;
    logic [3:0] ef, gf;
    int el, gl;
    @(negedge clk);
    a = 8'd200; b = 8'd7; mode = 4'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL middiv_in_ready got %b want 1", in_ready); else passes++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL middiv_out_valid got %b want 0", out_valid); else passes++;
    checks++; if (result !== 8'h00) $display("[TB] FAIL middiv_result got %h want 00", result); else passes++;
    checks++; if (flags !== 4'b0000) $display("[TB] FAIL middiv_flags got %b want 0000", flags); else passes++;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++; if (seen != 0) $display("[TB] FAIL middiv_no_result got %0d valid cycles want 0", seen); else passes++;
    model(8'd9, 8'd4, 4'd1, er, ef, el);
    start_op(8'd9, 8'd4, 4'd1, gr, gf, gl);
    checks++; if (gr !== er) $display("[TB] FAIL recover_result got %h want %h", gr, er); else passes++;
    checks++; if (gl != el) $display("[TB] FAIL recover_latency got %0d want %0d", gl, el); else passes++;
    finish_op();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_reset_mid_div();
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
